// File: rtl/him_row_unpacker.sv
// him_row_unpacker: reads one HIM row and streams its packed hit words.
// Optional HIM_UNPACK_CHECK_EN adds sticky err_dirty for junk above count.
module him_row_unpacker #(
    parameter int HITINFOBITS  = 16,
    parameter int MAXHITS      = 8,
    parameter int NCOLS_HIM    = HITINFOBITS * MAXHITS,
    parameter int ROWINDEXBITS = 10,
    parameter int MAXHITNBITS  = 4,
    parameter int RD_LATENCY   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ROWINDEXBITS-1:0] req_row,
    input  logic [MAXHITNBITS-1:0]  req_nhits,
    input  logic                    him_readReady,
    output logic                    him_readRow,
    output logic [ROWINDEXBITS-1:0] him_rowToRead,
    input  logic [NCOLS_HIM-1:0]    him_hitInfo,
    output logic                    hit_valid,
    input  logic                    hit_ready,
    output logic [HITINFOBITS-1:0]  hit_data,
    output logic [MAXHITNBITS-1:0]  hit_index,
    output logic                    hit_last,
    output logic [ROWINDEXBITS-1:0] hit_row,
    output logic                    row_done,
    output logic                    err_overflow
`ifdef HIM_UNPACK_CHECK_EN
    ,
    output logic                    err_dirty
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_UNPACK = 2'd3;

    localparam int LATW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LATW-1:0] LAT_INIT = LATW'(RD_LATENCY - 1);
    localparam logic [MAXHITNBITS-1:0] MAXC = MAXHITNBITS'(MAXHITS);
    localparam logic [MAXHITNBITS-1:0] ONE  = MAXHITNBITS'(1);

    logic [1:0]              state_q, state_d;
    logic [ROWINDEXBITS-1:0] row_q, row_d;
    logic [MAXHITNBITS-1:0]  cnt_q, cnt_d;
    logic [MAXHITNBITS-1:0]  idx_q, idx_d;
    logic [LATW-1:0]         lat_q, lat_d;
    logic [NCOLS_HIM-1:0]    sreg_q, sreg_d;
    logic                    hv_q, hv_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    // Row done holds off the next accept by one cycle.
    assign req_ready     = (state_q == S_IDLE) && !done_q;
    assign him_readRow   = (state_q == S_ISSUE) && him_readReady;
    assign him_rowToRead = row_q;
    assign hit_valid     = hv_q;
    assign hit_data      = sreg_q[HITINFOBITS-1:0];
    assign hit_index     = idx_q;
    assign hit_last      = hv_q && (idx_q == cnt_q - ONE);
    assign hit_row       = row_q;
    assign row_done      = done_q;
    assign err_overflow  = ovf_q;

`ifdef HIM_UNPACK_CHECK_EN
    logic dirty_q, dirty_d;
    logic dirty_hit;

    assign err_dirty = dirty_q;

    // Any nonzero slot at or beyond the hit count marks the row dirty.
    always_comb begin
        dirty_hit = 1'b0;
        for (int s = 0; s < MAXHITS; s++) begin
            if (s >= int'(cnt_q)) begin
                dirty_hit = dirty_hit |
                    (|him_hitInfo[s*HITINFOBITS +: HITINFOBITS]);
            end
        end
    end
`endif

    // Next-state logic for the request/read/unpack sequence.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        sreg_d  = sreg_q;
        hv_d    = hv_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
`ifdef HIM_UNPACK_CHECK_EN
        dirty_d = dirty_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    row_d = req_row;
                    if (req_nhits > MAXC) begin
                        cnt_d = MAXC;
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = req_nhits;
                    end
                    if (req_nhits == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (him_readReady) begin
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    sreg_d  = him_hitInfo;
                    idx_d   = '0;
                    hv_d    = 1'b1;
                    state_d = S_UNPACK;
`ifdef HIM_UNPACK_CHECK_EN
                    if (dirty_hit) begin
                        dirty_d = 1'b1;
                    end
`endif
                end else begin
                    lat_d = lat_q - LATW'(1);
                end
            end
            S_UNPACK: begin
                if (hv_q && hit_ready) begin
                    sreg_d = sreg_q >> HITINFOBITS;
                    idx_d  = idx_q + ONE;
                    if (hit_last) begin
                        hv_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any row in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            sreg_q  <= '0;
            hv_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef HIM_UNPACK_CHECK_EN
            dirty_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            sreg_q  <= sreg_d;
            hv_q    <= hv_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef HIM_UNPACK_CHECK_EN
            dirty_q <= dirty_d;
`endif
        end
    end

endmodule

// File: tb/tb_him_row_unpacker.sv
// Scoreboard bench for him_row_unpacker with a fixed-latency HIM model.
module tb_him_row_unpacker;

    localparam int HB = 16;
    localparam int MH = 8;
    localparam int NC = HB * MH;
    localparam int RB = 10;
    localparam int NB = 4;
    localparam int L  = 4;

    typedef struct packed {
        logic [HB-1:0] d;
        logic [NB-1:0] i;
        logic          l;
        logic [RB-1:0] r;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [RB-1:0] req_row = '0;
    logic [NB-1:0] req_nhits = '0;
    logic          him_readReady = 1'b1;
    logic          him_readRow;
    logic [RB-1:0] him_rowToRead;
    logic [NC-1:0] him_hitInfo;
    logic          hit_valid;
    logic          hit_ready = 1'b1;
    logic [HB-1:0] hit_data;
    logic [NB-1:0] hit_index;
    logic          hit_last;
    logic [RB-1:0] hit_row;
    logic          row_done;
    logic          err_overflow;
`ifdef HIM_UNPACK_CHECK_EN
    logic          err_dirty;
`endif

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   rd_cnt = 0;
    exp_t q[$];

    logic [NC-1:0] pipe_d [L];
    logic [L-1:0]  pipe_v = '0;

    him_row_unpacker dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_row(req_row),
        .req_nhits(req_nhits),
        .him_readReady(him_readReady),
        .him_readRow(him_readRow),
        .him_rowToRead(him_rowToRead),
        .him_hitInfo(him_hitInfo),
        .hit_valid(hit_valid),
        .hit_ready(hit_ready),
        .hit_data(hit_data),
        .hit_index(hit_index),
        .hit_last(hit_last),
        .hit_row(hit_row),
        .row_done(row_done),
        .err_overflow(err_overflow)
`ifdef HIM_UNPACK_CHECK_EN
        ,
        .err_dirty(err_dirty)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NC-1:0] him_row(input logic [RB-1:0] r);
        logic [NC-1:0] v;
        case (r)
            10'd5: v = {80'h0, 16'h0C0C, 16'h0B0B, 16'h0A0A};
            10'd9: v = {16'h8888, 16'h7777, 16'h6666, 16'h5555,
                        16'h4444, 16'h3333, 16'h2222, 16'h1111};
            10'd3: v = {80'h0, 16'h0100, 16'h0202, 16'h0101};
            default: v = {8{16'hDEAD}};
        endcase
        return v;
    endfunction

    // HIM model: data valid only in the cycle ending at the capture edge.
    always @(posedge clk) begin
        pipe_v[0] <= him_readRow;
        pipe_d[0] <= him_row(him_rowToRead);
        for (int k = 1; k < L; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
    end
    assign him_hitInfo = pipe_v[L-1] ? pipe_d[L-1] : '1;

    // Monitor: pop and compare every accepted hit word.
    always @(negedge clk) begin
        exp_t e;
        if (row_done) done_cnt++;
        if (him_readRow) rd_cnt++;
        if (hit_valid && hit_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL hit_unexpected: got data=%h idx=%0d", hit_data, hit_index);
            end else begin
                e = q.pop_front();
                if (hit_data !== e.d || hit_index !== e.i ||
                    hit_last !== e.l || hit_row !== e.r) begin
                    errors++;
                    $display("FAIL hit: got d=%h i=%0d l=%b r=%0d want d=%h i=%0d l=%b r=%0d",
                             hit_data, hit_index, hit_last, hit_row,
                             e.d, e.i, e.l, e.r);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic issue_req(input logic [RB-1:0] r, input logic [NB-1:0] n);
        logic [NC-1:0] row_v;
        int cnt;
        bit ok;
        exp_t e;
        row_v = him_row(r);
        cnt = (int'(n) > MH) ? MH : int'(n);
        for (int k = 0; k < cnt; k++) begin
            e.d = row_v[k*HB +: HB];
            e.i = NB'(k);
            e.l = (k == cnt - 1);
            e.r = r;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_row   = r;
        req_nhits = n;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got req_ready=0 want 1");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (done_cnt >= target) ok = 1'b1;
        end
        chk("row_done_count", done_cnt, target);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (hit_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL hit_valid_timeout: got 0 want 1");
        end
    endtask

    initial begin
        bit ok;
        int t;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_readRow", him_readRow, 0);
        chk("rst_overflow", err_overflow, 0);
        chk("rst_hit_data", hit_data, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Test 1: three hits, streaming
        issue_req(10'd5, 4'd3);
        wait_done(1);
        chk("t1_reads", rd_cnt, 1);
        chk("t1_queue", q.size(), 0);

        // Test 2: stall the first hit for five cycles
        hit_ready = 1'b0;
        issue_req(10'd5, 4'd3);
        wait_valid(ok);
        repeat (5) @(negedge clk);
        chk("t2_hold_data", hit_data, 32'h0A0A);
        chk("t2_hold_idx", hit_index, 0);
        chk("t2_hold_valid", hit_valid, 1);
        @(posedge clk); #1;
        hit_ready = 1'b1;
        wait_done(2);
        chk("t2_queue", q.size(), 0);

        // Test 3: zero hits, no read, done one cycle after accept
        issue_req(10'd7, 4'd0);
        @(negedge clk);
        chk("t3_done_pulse", row_done, 1);
        chk("t3_hit_valid", hit_valid, 0);
        wait_done(3);
        chk("t3_reads", rd_cnt, 2);

        // Test 4: readReady held low, then exact read latency
        him_readReady = 1'b0;
        issue_req(10'd5, 4'd3);
        repeat (10) @(negedge clk);
        chk("t4_no_read", rd_cnt, 2);
        @(posedge clk); #1;
        him_readReady = 1'b1;
        @(negedge clk);
        chk("t4_pulse", him_readRow, 1);
        // Pulse seen here is sampled by the next edge; valid follows L edges later.
        t = 0;
        ok = 1'b0;
        while (!ok && t < 50) begin
            @(negedge clk);
            t++;
            if (hit_valid) ok = 1'b1;
        end
        chk("t4_latency", t, L + 1);
        wait_done(4);
        chk("t4_reads", rd_cnt, 3);

        // Test 5: overflow clamps to MAXHITS
        issue_req(10'd9, 4'd12);
        wait_done(5);
        chk("t5_overflow", err_overflow, 1);
        chk("t5_queue", q.size(), 0);
`ifdef HIM_UNPACK_CHECK_EN
        chk("t5_dirty_clear", err_dirty, 0);
        issue_req(10'd3, 4'd2);
        wait_done(6);
        chk("t5_dirty_set", err_dirty, 1);
        chk("t5_dirty_queue", q.size(), 0);
`endif

        // Test 6: reset in the middle of unpacking
        hit_ready = 1'b0;
        issue_req(10'd5, 4'd3);
        wait_valid(ok);
        @(posedge clk); #1;
        hit_ready = 1'b1;
        @(posedge clk); #1;
        hit_ready = 1'b0;
        @(negedge clk);
        chk("t6_idx1", hit_index, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", hit_valid, 0);
        chk("t6_rst_ready", req_ready, 1);
        chk("t6_rst_idx", hit_index, 0);
        chk("t6_rst_data", hit_data, 0);
        chk("t6_rst_ovf", err_overflow, 0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        hit_ready = 1'b1;
        t = done_cnt;
        issue_req(10'd5, 4'd3);
        wait_done(t + 1);
        chk("t6_queue", q.size(), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
